config_frame_mem_rb: RTL and testbench

//  Clocked, parametrised tile configuration memory: replaces per-tile frame latches with CLK-registered frames.

---
 rtl/config_frame_mem_rb_pkg.sv | 29 ++
 rtl/config_frame_mem_rb_shifter.sv | 80 ++++++++
 rtl/config_frame_mem_rb.sv | 99 +++++++++
 tb/tb_config_frame_mem_rb.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/config_frame_mem_rb_pkg.sv
// Shared definitions for the clocked tile configuration memory with readback.
package config_frame_mem_rb_pkg;

  // Readback FSM states
  typedef enum logic [1:0] {
    RdIdle,
    RdLoad,
    RdShift
  } rdState_t;

  // Widest strobe bus the one-hot helpers accept
  localparam int unsigned MaxStrobeW = 256;

  // Index/counter width that stays at least one bit for degenerate sizes
  function automatic int unsigned cntWidth(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Exactly one bit set
  function automatic logic isOneHot(input logic [MaxStrobeW-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  // More than one bit set
  function automatic logic isMultiHot(input logic [MaxStrobeW-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) != '0);
  endfunction

endpackage

// File: rtl/config_frame_mem_rb_shifter.sv
// Readback serializer: snapshots one frame and streams it LSB first with valid/ready.
module config_frame_shifter
  import config_frame_mem_rb_pkg::*;
#(
  parameter int unsigned FrameBitsPerRow = 32
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       startRead,
  input  logic [FrameBitsPerRow-1:0] frameIn,
  input  logic                       ReadReady,
  output logic                       ReadData,
  output logic                       ReadValid,
  output logic                       ReadLast,
  output logic                       ReadIdle
);

  localparam int unsigned CntW = cntWidth(FrameBitsPerRow);
  localparam logic [CntW-1:0] LastIdx = CntW'(FrameBitsPerRow - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  rdState_t                   state;
  logic [FrameBitsPerRow-1:0] snapshot;
  logic [CntW-1:0]            cnt;
  logic [CntW-1:0]            nextCnt;

  assign nextCnt = cnt + CntOne;

  // Readback FSM with registered stream outputs; outputs only move on a handshake
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= RdIdle;
      snapshot  <= '0;
      cnt       <= '0;
      ReadData  <= 1'b0;
      ReadValid <= 1'b0;
      ReadLast  <= 1'b0;
      ReadIdle  <= 1'b1;
    end else begin
      case (state)
        RdIdle: begin
          if (startRead) begin
            state    <= RdLoad;
            ReadIdle <= 1'b0;
          end
        end
        RdLoad: begin
          snapshot  <= frameIn;
          cnt       <= '0;
          ReadData  <= frameIn[0];
          ReadValid <= 1'b1;
          ReadLast  <= (LastIdx == '0);
          state     <= RdShift;
        end
        RdShift: begin
          if (ReadReady) begin
            if (cnt == LastIdx) begin
              state     <= RdIdle;
              ReadData  <= 1'b0;
              ReadValid <= 1'b0;
              ReadLast  <= 1'b0;
              ReadIdle  <= 1'b1;
            end else begin
              cnt      <= nextCnt;
              ReadData <= snapshot[nextCnt];
              ReadLast <= (nextCnt == LastIdx);
            end
          end
        end
        default: begin
          state     <= RdIdle;
          ReadValid <= 1'b0;
          ReadLast  <= 1'b0;
          ReadIdle  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/config_frame_mem_rb.sv
// Clocked tile configuration memory: frame registers written from the column frame bus,
// strobe checking with sticky error flags, and a serial readback port.
module config_frame_mem_rb
  import config_frame_mem_rb_pkg::*;
#(
  parameter int unsigned              MaxFramesPerCol = 20,
  parameter int unsigned              FrameBitsPerRow = 32,
  parameter int unsigned              NoConfigBits    = 640,
  parameter logic [NoConfigBits-1:0]  ResetBitstream  = '0
) (
  input  logic                                   CLK,
  input  logic                                   RST,
  input  logic [FrameBitsPerRow-1:0]             FrameData,
  input  logic [MaxFramesPerCol-1:0]             FrameStrobe,
  input  logic                                   ReadReq,
  input  logic [cntWidth(MaxFramesPerCol)-1:0]   ReadFrame,
  input  logic                                   ReadReady,
  output logic                                   ReadData,
  output logic                                   ReadValid,
  output logic                                   ReadLast,
  output logic                                   ReadIdle,
  output logic                                   StrobeErr,
  output logic                                   ReadErr,
  output logic [NoConfigBits-1:0]                ConfigBits,
  output logic [NoConfigBits-1:0]                ConfigBits_N
);

  localparam int unsigned IdxW      = cntWidth(MaxFramesPerCol);
  localparam int unsigned TotalBits = MaxFramesPerCol * FrameBitsPerRow;
  // Bits beyond NoConfigBits are held at zero so they read back as 0
  localparam logic [TotalBits-1:0] ValidMask  = TotalBits'({NoConfigBits{1'b1}});
  localparam logic [TotalBits-1:0] ResetImage = TotalBits'(ResetBitstream);

  logic [TotalBits-1:0]       frameMem;
  logic [IdxW-1:0]            readIdx;
  logic [FrameBitsPerRow-1:0] selFrame;
  logic                       strobeOneHot;
  logic                       strobeMulti;
  logic                       readInRange;
  logic                       readAccept;

  assign strobeOneHot = isOneHot(MaxStrobeW'(FrameStrobe));
  assign strobeMulti  = isMultiHot(MaxStrobeW'(FrameStrobe));
  assign readInRange  = (32'(ReadFrame) < MaxFramesPerCol);
  assign readAccept   = ReadIdle && ReadReq && readInRange;
  assign selFrame     = frameMem[32'(readIdx) * FrameBitsPerRow +: FrameBitsPerRow];

  assign ConfigBits   = frameMem[NoConfigBits-1:0];
  assign ConfigBits_N = ~frameMem[NoConfigBits-1:0];

  // Frame register array: one-hot strobe writes exactly one frame, anything else writes none
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      frameMem <= ResetImage & ValidMask;
    end else if (strobeOneHot) begin
      for (int unsigned f = 0; f < MaxFramesPerCol; f++) begin
        if (FrameStrobe[f]) begin
          frameMem[f*FrameBitsPerRow +: FrameBitsPerRow] <=
            FrameData & ValidMask[f*FrameBitsPerRow +: FrameBitsPerRow];
        end
      end
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      StrobeErr <= 1'b0;
      ReadErr   <= 1'b0;
    end else begin
      if (strobeMulti) StrobeErr <= 1'b1;
      if (ReadIdle && ReadReq && !readInRange) ReadErr <= 1'b1;
    end
  end

  // Frame index latched at request time so ReadFrame may change during LOAD
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      readIdx <= '0;
    end else if (readAccept) begin
      readIdx <= ReadFrame;
    end
  end

  config_frame_shifter #(
    .FrameBitsPerRow(FrameBitsPerRow)
  ) shifter (
    .CLK       (CLK),
    .RST       (RST),
    .startRead (readAccept),
    .frameIn   (selFrame),
    .ReadReady (ReadReady),
    .ReadData  (ReadData),
    .ReadValid (ReadValid),
    .ReadLast  (ReadLast),
    .ReadIdle  (ReadIdle)
  );

endmodule

// File: tb/tb_config_frame_mem_rb.sv
// Bench for config_frame_mem_rb: directed scenarios plus randomized traffic against a frame-level model.
module tb_config_frame_mem_rb;

  localparam int unsigned NFrames = 20;
  localparam int unsigned NBits   = 32;
  localparam int unsigned NCfg    = 630;
  localparam logic [NCfg-1:0] ResetPat = {315{2'b01}};

  logic              CLK = 1'b0;
  logic              RST;
  logic [NBits-1:0]  FrameData;
  logic [NFrames-1:0] FrameStrobe;
  logic              ReadReq;
  logic [4:0]        ReadFrame;
  logic              ReadReady;
  logic              ReadData, ReadValid, ReadLast, ReadIdle, StrobeErr, ReadErr;
  logic [NCfg-1:0]   ConfigBits, ConfigBits_N;

  config_frame_mem_rb #(
    .MaxFramesPerCol(NFrames),
    .FrameBitsPerRow(NBits),
    .NoConfigBits   (NCfg),
    .ResetBitstream (ResetPat)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .ReadReq     (ReadReq),
    .ReadFrame   (ReadFrame),
    .ReadReady   (ReadReady),
    .ReadData    (ReadData),
    .ReadValid   (ReadValid),
    .ReadLast    (ReadLast),
    .ReadIdle    (ReadIdle),
    .StrobeErr   (StrobeErr),
    .ReadErr     (ReadErr),
    .ConfigBits  (ConfigBits),
    .ConfigBits_N(ConfigBits_N)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Reference model: frame contents, sticky flags, queue of bits still owed by readback
  logic [NBits-1:0] mFrames [NFrames];
  bit               mStrobeErr, mReadErr;
  bit               mQ [$];
  bit               mInLoad;
  logic [NBits-1:0] collected;

  task automatic checkVal(input string tag, input logic [639:0] got, input logic [639:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NBits-1:0] frameMask(input int f);
    logic [NBits-1:0] m = '0;
    for (int b = 0; b < NBits; b++)
      if (f * NBits + b < NCfg) m[b] = 1'b1;
    return m;
  endfunction

  function automatic logic [NCfg-1:0] expCfg();
    logic [NCfg-1:0] v = '0;
    for (int f = 0; f < NFrames; f++)
      for (int b = 0; b < NBits; b++)
        if (f * NBits + b < NCfg) v[f*NBits+b] = mFrames[f][b];
    return v;
  endfunction

  task automatic modelReset();
    logic [NCfg-1:0] rp = ResetPat;
    for (int f = 0; f < NFrames; f++)
      for (int b = 0; b < NBits; b++)
        mFrames[f][b] = (f * NBits + b < NCfg) ? rp[f*NBits+b] : 1'b0;
    mStrobeErr = 0;
    mReadErr   = 0;
    mQ.delete();
    mInLoad = 0;
  endtask

  task automatic checkOutputs();
    logic [NCfg-1:0] cfg, cfgN;
    bit expValid;
    cfg  = expCfg();
    cfgN = ~cfg;
    expValid = (mQ.size() != 0) && !mInLoad;
    checkVal("ConfigBits", ConfigBits, cfg);
    checkVal("ConfigBits_N", ConfigBits_N, cfgN);
    checkVal("StrobeErr", StrobeErr, mStrobeErr);
    checkVal("ReadErr", ReadErr, mReadErr);
    checkVal("ReadIdle", ReadIdle, mQ.size() == 0);
    checkVal("ReadValid", ReadValid, expValid);
    if (expValid) begin
      checkVal("ReadData", ReadData, mQ[0]);
      checkVal("ReadLast", ReadLast, mQ.size() == 1);
    end else begin
      checkVal("ReadLastIdle", ReadLast, 1'b0);
    end
  endtask

  // One clock: inputs already driven; advance model by one edge and compare
  task automatic step();
    bit idlePre, validPre;
    int ones;
    idlePre  = (mQ.size() == 0);
    validPre = !idlePre && !mInLoad;
    if (validPre && ReadReady) collected = {ReadData, collected[NBits-1:1]};
    @(posedge CLK);
    #1;
    if (validPre && ReadReady) void'(mQ.pop_front());
    mInLoad = 0;
    ones = $countones(FrameStrobe);
    if (ones == 1) begin
      for (int f = 0; f < NFrames; f++)
        if (FrameStrobe[f]) mFrames[f] = FrameData & frameMask(f);
    end else if (ones > 1) begin
      mStrobeErr = 1;
    end
    if (idlePre && ReadReq) begin
      if (ReadFrame < NFrames) begin
        for (int b = 0; b < NBits; b++) mQ.push_back(mFrames[ReadFrame][b]);
        mInLoad = 1;
      end else begin
        mReadErr = 1;
      end
    end
    checkOutputs();
  endtask

  task automatic idleInputs();
    FrameData   = '0;
    FrameStrobe = '0;
    ReadReq     = 1'b0;
    ReadFrame   = '0;
    ReadReady   = 1'b0;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without a clock
  task automatic resetDut();
    RST = 1'b1;
    #1;
    modelReset();
    checkOutputs();
    checkVal("RstReadData", ReadData, 1'b0);
    #2;
    RST = 1'b0;
  endtask

  task automatic readFrame(input logic [4:0] idx, input int cycles, input bit toggleReady,
                           input int rewriteAt, input logic [NFrames-1:0] rewriteStrobe);
    collected = '0;
    ReadReq   = 1'b1;
    ReadFrame = idx;
    ReadReady = 1'b1;
    step();
    ReadReq = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      ReadReady   = toggleReady ? i[0] : 1'b1;
      FrameStrobe = (i == rewriteAt) ? rewriteStrobe : '0;
      FrameData   = '0;
      step();
    end
    FrameStrobe = '0;
  endtask

  initial begin
    RST = 1'b1;
    idleInputs();
    collected = '0;
    #2;
    modelReset();
    checkOutputs();
    checkVal("RstReadData", ReadData, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    step();

    // Single-frame write lands in bits 95:64 one cycle later
    FrameStrobe = 20'h00004;
    FrameData   = 32'hDEADBEEF;
    step();
    checkVal("Frame2Write", ConfigBits[95:64], 32'hDEADBEEF);
    FrameStrobe = '0;
    step();

    // Multi-hot strobe writes nothing and latches StrobeErr
    FrameStrobe = 20'h00003;
    FrameData   = 32'h12345678;
    step();
    checkVal("MultiHotErr", StrobeErr, 1'b1);
    FrameStrobe = 20'h00010;
    FrameData   = 32'hA5A5_0F0F;
    step();
    FrameStrobe = '0;
    step();
    checkVal("StrobeErrSticky", StrobeErr, 1'b1);

    // Plain readback of frame 2
    readFrame(5'd2, 36, 1'b0, -1, '0);
    checkVal("ReadbackWord", collected, 32'hDEADBEEF);
    checkVal("ReadbackDone", ReadIdle, 1'b1);

    // Backpressure with frame 2 cleared mid-stream; stream keeps the snapshot
    readFrame(5'd2, 70, 1'b1, 10, 20'h00004);
    checkVal("StalledWord", collected, 32'hDEADBEEF);
    checkVal("Frame2Cleared", ConfigBits[95:64], 32'h0);

    // Out-of-range frame index
    ReadReq   = 1'b1;
    ReadFrame = 5'd20;
    step();
    ReadReq = 1'b0;
    step();
    checkVal("ReadErrOOR", ReadErr, 1'b1);
    checkVal("ReadErrNoValid", ReadValid, 1'b0);

    // Last frame is partially populated: bits 22..31 are discarded
    FrameStrobe = 20'h80000;
    FrameData   = 32'hFFFFFFFF;
    step();
    FrameStrobe = '0;
    readFrame(5'd19, 36, 1'b0, -1, '0);
    checkVal("PartialFrame", collected, 32'h003FFFFF);

    // Reset during SHIFT
    ReadReq   = 1'b1;
    ReadFrame = 5'd4;
    ReadReady = 1'b0;
    step();
    ReadReq = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checkVal("ShiftBeforeRst", ReadValid, 1'b1);
    resetDut();
    checkVal("RstMidShift", ReadValid, 1'b0);
    step();

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      int unsigned r;
      if (i == 1200) resetDut();
      r = $urandom_range(0, 9);
      if (r == 0)      FrameStrobe = '0;
      else if (r == 1) FrameStrobe = NFrames'($urandom);
      else             FrameStrobe = NFrames'(1) << $urandom_range(0, NFrames - 1);
      FrameData = $urandom;
      ReadReq   = ($urandom_range(0, 3) == 0);
      ReadFrame = 5'($urandom_range(0, 21));
      ReadReady = ($urandom_range(0, 2) != 0);
      step();
    end

    idleInputs();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
